axi_traffic_agent: RTL and testbench

- Synthesizable traffic agent bundling three bus roles used around the AES kernel bench:
  - an AXI4-Lite master driven by a simple command/response port, for control-register access;
  - a 128-bit AXI4-Stream master fed from a source port;
  - a 128-bit AXI4-Stream slave draining into a sink port.
- Sits between a sequencer and the kernel's s_axi_control / axis_slvN / axis_mstN ports.

---
 rtl/axi_traffic_agent.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_traffic_agent.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_agent.sv
// -----------------------------------------------------------------------------
// axi_traffic_agent
//
// Traffic agent that bundles three bus roles around the AES kernel:
//   * AXI4-Lite master, driven by a one-at-a-time command/response port.
//   * AXI4-Stream master (one-deep register slice) fed from a source port.
//   * AXI4-Stream slave (one-deep register slice) draining into a sink port.
//
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   cmd_*                    command in: valid/ready, write flag, addr, wdata
//   rsp_*                    one-cycle completion pulse with rdata and resp
//   m_axi_*                  AXI4-Lite master (aw/w/b/ar/r channels)
//   src_* -> m_axis_*        stream master path
//   s_axis_* -> snk_*        stream slave path
//   mst_beats, slv_beats     free-running handshake counters (wrap at 2^32)
// -----------------------------------------------------------------------------
module axi_traffic_agent #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TDATA_W = 128
) (
    input  logic                aclk,
    input  logic                areset,
    // command / response
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    // AXI4-Lite master
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    // stream master path
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [TDATA_W-1:0]  src_data,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [TDATA_W-1:0]  m_axis_tdata,
    // stream slave path
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [TDATA_W-1:0]  s_axis_tdata,
    output logic                snk_valid,
    input  logic                snk_ready,
    output logic [TDATA_W-1:0]  snk_data,
    // counters
    output logic [31:0]         mst_beats,
    output logic [31:0]         slv_beats
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    // aw and w complete independently; each remembers its own handshake
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic                aw_hs, w_hs;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;

    // ---------------- AXI4-Lite FSM: state register ----------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // ---------------- AXI4-Lite FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    rdata_d   = '0;   // writes report zero read data
                    resp_d    = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // both channels may finish in the same cycle
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    state_d = S_DONE;
                end
            end
            S_RADDR: begin
                if (m_axi_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- AXI4-Lite FSM: outputs ----------------
    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        m_axi_awvalid = (state_q == S_WADDR) && !aw_done_q;
        m_axi_wvalid  = (state_q == S_WADDR) && !w_done_q;
        m_axi_bready  = (state_q == S_WRESP);
        m_axi_arvalid = (state_q == S_RADDR);
        m_axi_rready  = (state_q == S_RDATA);
        rsp_valid     = (state_q == S_DONE);
        m_axi_awaddr  = addr_q;
        m_axi_araddr  = addr_q;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = '1;
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
    end

    // ---------------- stream master slice ----------------
    logic               m_tvalid_q;
    logic [TDATA_W-1:0] m_tdata_q;

    // accept a new word whenever the slice is empty or draining this cycle
    assign src_ready     = !m_tvalid_q | m_axis_tready;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else if (src_valid && src_ready) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= src_data;
        end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    // ---------------- stream slave slice ----------------
    logic               snk_valid_q;
    logic [TDATA_W-1:0] snk_data_q;

    assign s_axis_tready = !snk_valid_q | snk_ready;
    assign snk_valid     = snk_valid_q;
    assign snk_data      = snk_data_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            snk_valid_q <= 1'b0;
            snk_data_q  <= '0;
        end else if (s_axis_tvalid && s_axis_tready) begin
            snk_valid_q <= 1'b1;
            snk_data_q  <= s_axis_tdata;
        end else if (snk_ready) begin
            snk_valid_q <= 1'b0;
        end
    end

    // ---------------- handshake counters ----------------
    logic [31:0] mst_beats_q, slv_beats_q;

    assign mst_beats = mst_beats_q;
    assign slv_beats = slv_beats_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            mst_beats_q <= '0;
            slv_beats_q <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) mst_beats_q <= mst_beats_q + 32'd1;
            if (s_axis_tvalid && s_axis_tready) slv_beats_q <= slv_beats_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_axi_traffic_agent.sv
`timescale 1ns/1ps

module tb_axi_traffic_agent;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TDATA_W = 128;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic                cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [DATA_W-1:0]   cmd_wdata = '0;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic [ADDR_W-1:0]   m_axi_awaddr, m_axi_araddr;
  logic                m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic                m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic                m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]          m_axi_bresp = 2'd0, m_axi_rresp = 2'd0;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic [DATA_W-1:0]   m_axi_rdata = '0;
  logic                src_valid = 1'b0, src_ready;
  logic [TDATA_W-1:0]  src_data = '0;
  logic                m_axis_tvalid, m_axis_tready = 1'b1;
  logic [TDATA_W-1:0]  m_axis_tdata;
  logic                s_axis_tvalid = 1'b0, s_axis_tready;
  logic [TDATA_W-1:0]  s_axis_tdata = '0;
  logic                snk_valid, snk_ready = 1'b1;
  logic [TDATA_W-1:0]  snk_data;
  logic [31:0]         mst_beats, slv_beats;

  axi_traffic_agent #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TDATA_W(TDATA_W)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .mst_beats(mst_beats), .slv_beats(slv_beats)
  );

  int checks = 0;
  int errors = 0;

  int unsigned mem [int unsigned];
  bit          got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
  bit          b_hold = 0, aw_delay = 0, reading = 0;
  int          wcnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, w_on_read = 0;
  logic [31:0] aw_cap = '0, w_cap = '0, r_data_v = '0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [3:0]  wstrb_cap = '0;
  logic [1:0]  b_resp_v = 2'd0;

  always @(negedge aclk) begin
    m_axi_awready = aw_delay ? (got_w && wcnt >= 3) : 1'b1;
    if (got_w) wcnt++;
    m_axi_wready  = 1'b1;
    m_axi_arready = 1'b1;
    m_axi_bvalid  = b_pend && !b_hold;
    m_axi_bresp   = b_resp_v;
    m_axi_rvalid  = r_pend;
    m_axi_rdata   = r_data_v;
    m_axi_rresp   = 2'd0;
    #1;
    if (areset) begin
      got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; wcnt = 0;
    end else begin
      if (reading && m_axi_wvalid) w_on_read++;
      if (m_axi_awvalid && m_axi_awready) begin aw_cnt++; got_aw = 1; aw_cap = m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin
        w_cnt++; got_w = 1; w_cap = m_axi_wdata; wstrb_cap = m_axi_wstrb;
      end
      if (m_axi_bvalid && m_axi_bready) begin b_cnt++; b_pend = 0; end
      if (m_axi_rvalid && m_axi_rready) r_pend = 0;
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend   = 1;
        r_data_v = mem.exists(m_axi_araddr) ? mem[m_axi_araddr] : m_axi_araddr + 32'h100;
      end
      if (got_aw && got_w) begin
        b_pend   = 1;
        b_resp_v = (aw_cap == err_addr) ? 2'd2 : 2'd0;
        if (aw_cap != err_addr) mem[aw_cap] = w_cap;
        got_aw = 0; got_w = 0; wcnt = 0;
      end
    end
  end

  int rsp_pulses = 0;
  always @(negedge aclk) begin
    #1;
    if (rsp_valid === 1'b1) rsp_pulses++;
  end

  bit                  mon_en = 1;
  int                  mt_mode = 2;
  bit                  snk_tog = 0;
  bit                  m_stall = 0;
  logic [TDATA_W-1:0]  m_stall_data = '0;
  logic [TDATA_W-1:0]  m_sent[$], m_rx[$], s_sent[$], s_rx[$];

  always @(negedge aclk) begin
    case (mt_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
    #1;
    if (mon_en && !areset) begin
      if (m_stall) begin
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, m_stall_data}) begin
          errors++; $error("FAIL m_hold_while_stalled");
        end
      end
      m_stall      = m_axis_tvalid && !m_axis_tready;
      m_stall_data = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) m_rx.push_back(m_axis_tdata);
    end else begin
      m_stall = 0;
    end
  end

  always @(negedge aclk) begin
    snk_ready = snk_tog ? ~snk_ready : 1'b1;
    #1;
    if (mon_en && !areset) begin
      if (snk_valid && !snk_ready) begin
        checks++;
        if (s_axis_tready !== 1'b0) begin
          errors++; $error("FAIL s_tready_when_full");
        end
      end
      if (snk_valid && snk_ready) s_rx.push_back(snk_data);
    end
  end

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic [1:0] rs,
                        output int lat, output bit busy_ok);
    int n;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    #2;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge aclk); #2; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $error("FAIL cmd_accept"); end
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    #2;
    lat = 2; busy_ok = 1; n = 0;
    while (!rsp_valid && n < 100) begin
      if (cmd_ready !== 1'b0) busy_ok = 0;
      @(negedge aclk); #2; lat++; n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $error("FAIL rsp_seen"); end
    if (cmd_ready !== 1'b0) busy_ok = 0;
    rd = rsp_rdata;
    rs = rsp_resp;
    @(negedge aclk); #2;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $error("FAIL rsp_single_cycle"); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $error("FAIL idle_after_rsp"); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]        rd;
    logic [1:0]         rs;
    logic [TDATA_W-1:0] w;
    int                 lat, n, p0, a0, w0, b0;
    bit                 bok;

    // ---------------- reset ----------------
    repeat (50) @(negedge aclk);
    #2;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $error("FAIL rst_cmd_ready"); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $error("FAIL rst_rsp_valid"); end
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
      errors++; $error("FAIL rst_aw_w_ar");
    end
    checks++;
    if ({m_axis_tvalid, snk_valid} !== 2'b0) begin errors++; $error("FAIL rst_stream_valids"); end
    checks++;
    if ({mst_beats, slv_beats} !== 64'd0) begin errors++; $error("FAIL rst_counters"); end
    checks++;
    if ({m_axi_awaddr, rsp_rdata, m_axis_tdata, snk_data} !== 320'd0) begin
      errors++; $error("FAIL rst_data");
    end
    @(negedge aclk);
    areset = 1'b0;

    // ---------------- 1: read sweep ----------------
    reading = 1; p0 = rsp_pulses;
    for (int a = 0; a <= 32'h60; a += 8) begin
      do_cmd(1'b0, 32'(a), 32'h0, rd, rs, lat, bok);
      checks++;
      if (rd !== 32'(a) + 32'h100) begin errors++; $error("FAIL rd_data 0x%0h", rd); end
      checks++;
      if (rs !== 2'd0) begin errors++; $error("FAIL rd_resp"); end
      checks++;
      if (bok !== 1'b1) begin errors++; $error("FAIL rd_busy"); end
      if (a == 0) begin
        checks++;
        if (lat !== 4) begin errors++; $error("FAIL rd_latency %0d", lat); end
      end
    end
    reading = 0;
    checks++;
    if (rsp_pulses - p0 !== 13) begin errors++; $error("FAIL rd_pulses"); end
    checks++;
    if (w_on_read !== 0) begin errors++; $error("FAIL rd_no_wvalid"); end

    // ---------------- 2: write with late awready, read back ----------------
    aw_delay = 1; a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_cmd(1'b1, 32'h10, 32'hFFFF_FFFF, rd, rs, lat, bok);
    aw_delay = 0;
    checks++;
    if (aw_cnt - a0 !== 1) begin errors++; $error("FAIL wr_aw_once"); end
    checks++;
    if (w_cnt - w0 !== 1) begin errors++; $error("FAIL wr_w_once"); end
    checks++;
    if (b_cnt - b0 !== 1) begin errors++; $error("FAIL wr_b_once"); end
    checks++;
    if (aw_cap !== 32'h10) begin errors++; $error("FAIL wr_awaddr"); end
    checks++;
    if (wstrb_cap !== 4'hF) begin errors++; $error("FAIL wr_wstrb"); end
    checks++;
    if (rs !== 2'd0) begin errors++; $error("FAIL wr_resp"); end
    checks++;
    if (rd !== 32'h0) begin errors++; $error("FAIL wr_rdata_zero"); end
    checks++;
    if (bok !== 1'b1) begin errors++; $error("FAIL wr_busy"); end
    checks++;
    if (!(lat > 4)) begin errors++; $error("FAIL wr_delayed_longer %0d", lat); end
    do_cmd(1'b0, 32'h10, 32'h0, rd, rs, lat, bok);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $error("FAIL rb_data"); end

    // ---------------- 3: SLVERR on write ----------------
    err_addr = 32'h20;
    do_cmd(1'b1, 32'h20, $urandom, rd, rs, lat, bok);
    err_addr = 32'hFFFF_FFFF;
    checks++;
    if (rs !== 2'd2) begin errors++; $error("FAIL err_resp"); end
    checks++;
    if (lat !== 4) begin errors++; $error("FAIL err_wr_latency %0d", lat); end

    // ---------------- 4: stream master, random tready ----------------
    mt_mode = 1;
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      @(negedge aclk);
      src_valid = 1'b1; src_data = w;
      #2; n = 0;
      while (!src_ready && n < 200) begin @(negedge aclk); #2; n++; end
      checks++;
      if (src_ready !== 1'b1) begin errors++; $error("FAIL src_accept"); end
      m_sent.push_back(w);
    end
    @(negedge aclk);
    src_valid = 1'b0;
    #2; n = 0;
    while (m_axis_tvalid && n < 200) begin @(negedge aclk); #2; n++; end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $error("FAIL m_drained"); end
    checks++;
    if (m_rx.size() !== 16) begin errors++; $error("FAIL m_count %0d", m_rx.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < m_rx.size()) begin
        checks++;
        if (m_rx[i] !== m_sent[i]) begin errors++; $error("FAIL m_word %0d", i); end
      end
    end
    checks++;
    if (mst_beats !== 32'd16) begin errors++; $error("FAIL mst_beats"); end
    mt_mode = 2;

    // ---------------- 5: stream slave, toggling snk_ready ----------------
    snk_tog = 1;
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tdata = w;
      #2; n = 0;
      while (!s_axis_tready && n < 200) begin @(negedge aclk); #2; n++; end
      checks++;
      if (s_axis_tready !== 1'b1) begin errors++; $error("FAIL s_accept"); end
      s_sent.push_back(w);
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    #2; n = 0;
    while (snk_valid && n < 200) begin @(negedge aclk); #2; n++; end
    checks++;
    if (snk_valid !== 1'b0) begin errors++; $error("FAIL s_drained"); end
    checks++;
    if (s_rx.size() !== 16) begin errors++; $error("FAIL s_count %0d", s_rx.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < s_rx.size()) begin
        checks++;
        if (s_rx[i] !== s_sent[i]) begin errors++; $error("FAIL s_word %0d", i); end
      end
    end
    checks++;
    if (slv_beats !== 32'd16) begin errors++; $error("FAIL slv_beats"); end
    snk_tog = 0;

    // ---------------- 6: reset during WRESP with a word parked on m_axis ----------------
    mt_mode = 0;
    @(negedge aclk);
    src_valid = 1'b1; src_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge aclk);
    src_valid = 1'b0;
    #2;
    checks++;
    if (m_axis_tvalid !== 1'b1) begin errors++; $error("FAIL park_tvalid"); end
    b_hold = 1;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = $urandom;
    #2;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $error("FAIL rst6_accept"); end
    @(negedge aclk);
    cmd_valid = 1'b0;
    #2; n = 0;
    while (!m_axi_bready && n < 50) begin @(negedge aclk); #2; n++; end
    checks++;
    if (m_axi_bready !== 1'b1) begin errors++; $error("FAIL rst6_in_wresp"); end
    mon_en = 0; p0 = rsp_pulses;
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    #2;
    checks++;
    if ({m_axis_tvalid, snk_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 5'b0) begin
      errors++; $error("FAIL rst6_valids");
    end
    checks++;
    if ({m_axi_bready, m_axi_rready} !== 2'b0) begin errors++; $error("FAIL rst6_readies"); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $error("FAIL rst6_cmd_ready"); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $error("FAIL rst6_rsp_valid"); end
    checks++;
    if ({mst_beats, slv_beats} !== 64'd0) begin errors++; $error("FAIL rst6_counters"); end
    areset = 1'b0; b_hold = 0; mt_mode = 2; mon_en = 1;
    repeat (5) @(negedge aclk);
    checks++;
    if (rsp_pulses - p0 !== 0) begin errors++; $error("FAIL rst6_no_rsp"); end
    do_cmd(1'b0, 32'h10, 32'h0, rd, rs, lat, bok);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $error("FAIL post_rst_read"); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
